// File: rtl/alu_sequencer.sv
// ALU sequencer: accepts one encoded operation at a time, drives the ALU operands and
// one-hot select for as long as the op needs, then holds the captured result for the consumer.
module alu_sequencer #(
  parameter int DIV_CYCLES = 34
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [11:0] alu_select,
  input  logic [31:0] alu_z,
  input  logic [31:0] alu_hi,
  input  logic [31:0] alu_lo,
  input  logic        alu_divide_by_zero,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_z,
  output logic [31:0] resp_hi,
  output logic [31:0] resp_lo,
  output logic        resp_dbz,
  output logic        resp_illegal
);

  typedef enum logic [1:0] {IDLE, EXEC, WAIT_DIV, RESP} state_t;

  localparam int              CW       = (DIV_CYCLES > 2) ? $clog2(DIV_CYCLES) : 1;
  localparam logic [CW-1:0]   CNT_INIT = CW'(DIV_CYCLES - 2);
  localparam logic [3:0]      OP_DIV   = 4'd9;
  localparam logic [3:0]      OP_LAST  = 4'd11;
  localparam logic [11:0]     SEL_DIV  = 12'h200;

  state_t        state_q, state_d;
  logic [3:0]    op_q, op_d;
  logic [31:0]   a_q, a_d, b_q, b_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sticky_q, sticky_d;
  logic [31:0]   z_q, z_d, hi_q, hi_d, lo_q, lo_d;
  logic          dbz_q, dbz_d, ill_q, ill_d;
  logic [11:0]   sel;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q  <= IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      sticky_q <= 1'b0;
      z_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      dbz_q    <= 1'b0;
      ill_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cnt_q    <= cnt_d;
      sticky_q <= sticky_d;
      z_q      <= z_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      dbz_q    <= dbz_d;
      ill_q    <= ill_d;
    end
  end

  // Results are captured from the ALU's combinational outputs in the last cycle the
  // select is still asserted; the ALU zeroes hi/lo as soon as the select drops.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    cnt_d    = cnt_q;
    sticky_d = sticky_q;
    z_d      = z_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    dbz_d    = dbz_q;
    ill_d    = ill_q;
    sel      = '0;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          a_d  = req_a;
          b_d  = req_b;
          op_d = req_op;
          if (req_op > OP_LAST) begin
            z_d     = '0;
            hi_d    = '0;
            lo_d    = '0;
            dbz_d   = 1'b0;
            ill_d   = 1'b1;
            state_d = RESP;
          end else begin
            state_d = EXEC;
          end
        end
      end
      EXEC: begin
        sel = 12'd1 << op_q;
        if (op_q == OP_DIV) begin
          cnt_d    = CNT_INIT;
          sticky_d = alu_divide_by_zero;
          state_d  = WAIT_DIV;
        end else begin
          z_d     = alu_z;
          hi_d    = alu_hi;
          lo_d    = alu_lo;
          dbz_d   = 1'b0;
          ill_d   = 1'b0;
          state_d = RESP;
        end
      end
      WAIT_DIV: begin
        sel      = SEL_DIV;
        sticky_d = sticky_q | alu_divide_by_zero;
        if (cnt_q == '0) begin
          z_d     = '0;
          hi_d    = alu_hi;
          lo_d    = alu_lo;
          dbz_d   = sticky_q | alu_divide_by_zero;
          ill_d   = 1'b0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Select decodes straight from registered state so an async clear drops it at once.
  assign alu_select   = sel;
  assign alu_a        = a_q;
  assign alu_b        = b_q;
  assign req_ready    = (state_q == IDLE);
  assign resp_valid   = (state_q == RESP);
  assign resp_z       = z_q;
  assign resp_hi      = hi_q;
  assign resp_lo      = lo_q;
  assign resp_dbz     = dbz_q;
  assign resp_illegal = ill_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: a behavioural ALU stand-in plus a transaction-level
// reference model, exercised with directed cases and randomized traffic.
module tb_alu_sequencer;

  localparam int DIV = 34;

  logic        clk = 1'b0;
  logic        clr;
  logic        req_valid, req_ready;
  logic [3:0]  req_op;
  logic [31:0] req_a, req_b;
  logic [31:0] alu_a, alu_b;
  logic [11:0] alu_select;
  logic [31:0] alu_z, alu_hi, alu_lo;
  logic        alu_divide_by_zero;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_z, resp_hi, resp_lo;
  logic        resp_dbz, resp_illegal;

  int   totalChecks = 0;
  int   badChecks   = 0;
  int   dbzAt       = 0;
  logic dbzNoise    = 1'b0;
  logic [5:0] divCnt;

  always #5 clk = ~clk;

  alu_sequencer #(.DIV_CYCLES(DIV)) dut (
    .clk(clk), .clr(clr),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_select(alu_select),
    .alu_z(alu_z), .alu_hi(alu_hi), .alu_lo(alu_lo),
    .alu_divide_by_zero(alu_divide_by_zero),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_z(resp_z), .resp_hi(resp_hi), .resp_lo(resp_lo),
    .resp_dbz(resp_dbz), .resp_illegal(resp_illegal)
  );

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    totalChecks++;
    if (got !== exp) begin
      badChecks++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // ALU arithmetic as {z, hi, lo}; divide reports junk on z, which the sequencer must discard
  function automatic logic [95:0] aluOut(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] z, hi, lo;
    logic [63:0] w;
    logic [4:0]  s;
    z = '0; hi = '0; lo = '0; s = b[4:0]; w = {a, a};
    case (op)
      4'd0: z = a + b;
      4'd1: z = a - b;
      4'd2: z = a >> s;
      4'd3: z = a << s;
      4'd4: begin w = w >> s; z = w[31:0]; end
      4'd5: begin w = w << s; z = w[63:32]; end
      4'd6: z = a & b;
      4'd7: z = a | b;
      4'd8: begin w = {32'd0, a} * {32'd0, b}; hi = w[63:32]; lo = w[31:0]; end
      4'd9: begin
        z = a ^ b;
        if (b == 0) begin hi = a; lo = '1; end
        else begin lo = a / b; hi = a % b; end
      end
      4'd10: z = -a;
      4'd11: z = ~a;
      default: ;
    endcase
    return {z, hi, lo};
  endfunction

  // ALU stand-in: divider only produces hi/lo in the last cycle of a DIV-long hold
  always @(posedge clk or negedge clr) begin
    if (!clr) divCnt <= '0;
    else if (alu_select == 12'h200) divCnt <= divCnt + 6'd1;
    else divCnt <= '0;
  end

  always_comb begin
    logic [95:0] r;
    r = '0;
    alu_divide_by_zero = dbzNoise;
    for (int i = 0; i < 12; i++)
      if (alu_select == (12'd1 << i)) r = aluOut(4'(i), alu_a, alu_b);
    if (alu_select == 12'h200) begin
      alu_divide_by_zero = (alu_b == 0) && (int'(divCnt) == dbzAt);
      if (int'(divCnt) != DIV - 1) r[63:0] = '0;
    end
    {alu_z, alu_hi, alu_lo} = r;
  end

  task automatic checkResetState(input string tag);
    checkOutput({tag, " req_ready"}, req_ready, 1);
    checkOutput({tag, " select"}, alu_select, 0);
    checkOutput({tag, " alu_a"}, alu_a, 0);
    checkOutput({tag, " alu_b"}, alu_b, 0);
    checkOutput({tag, " resp_valid"}, resp_valid, 0);
    checkOutput({tag, " resp_z"}, resp_z, 0);
    checkOutput({tag, " resp_hi"}, resp_hi, 0);
    checkOutput({tag, " resp_lo"}, resp_lo, 0);
    checkOutput({tag, " resp_dbz"}, resp_dbz, 0);
    checkOutput({tag, " resp_illegal"}, resp_illegal, 0);
  endtask

  // One full transaction: request, timing of select/valid, result, back-pressure, handshake
  task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                               input int holdCycles);
    logic [95:0] r;
    logic [31:0] ez, ehi, elo;
    logic        edbz, eill;
    logic [11:0] selExp;
    int selLen, validAt, selCount, selWrong, firstValid, heldBad;
    eill = (op >= 12);
    selExp  = eill ? 12'd0 : (12'd1 << op);
    selLen  = eill ? 0 : (op == 9) ? DIV : 1;
    validAt = eill ? 1 : (op == 9) ? DIV + 1 : 2;
    r = aluOut(op, a, b);
    ez = eill ? 32'd0 : (op == 9) ? 32'd0 : r[95:64];
    ehi = eill ? 32'd0 : r[63:32];
    elo = eill ? 32'd0 : r[31:0];
    edbz = (op == 9) && (b == 0);

    @(negedge clk);
    checkOutput("req_ready before request", req_ready, 1);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    dbzAt = $urandom_range(0, DIV - 1);
    @(posedge clk);
    selCount = 0; selWrong = 0; firstValid = -1;
    for (int k = 1; k <= DIV + 8 && firstValid < 0; k++) begin
      @(negedge clk);
      req_valid = 1'($urandom_range(0, 1));
      req_op = 4'($urandom); req_a = $urandom; req_b = $urandom;
      dbzNoise = 1'($urandom_range(0, 1));
      if (alu_select != 0) begin
        selCount++;
        if (alu_select != selExp || k > selLen) selWrong++;
      end
      if (k == 1 && !eill) begin
        checkOutput("alu_a operand", alu_a, a);
        checkOutput("alu_b operand", alu_b, b);
      end
      if (resp_valid) firstValid = k;
    end
    checkOutput("select cycles", selCount, selLen);
    checkOutput("select wrong value", selWrong, 0);
    checkOutput("resp_valid latency", firstValid, validAt);
    checkOutput("req_ready while busy", req_ready, 0);
    checkOutput("select in RESP", alu_select, 0);
    checkOutput("resp_z", resp_z, ez);
    checkOutput("resp_hi", resp_hi, ehi);
    checkOutput("resp_lo", resp_lo, elo);
    checkOutput("resp_dbz", resp_dbz, edbz);
    checkOutput("resp_illegal", resp_illegal, eill);

    if (holdCycles > 0) begin
      heldBad = 0;
      repeat (holdCycles) begin
        @(negedge clk);
        req_valid = 1'($urandom_range(0, 1));
        dbzNoise = 1'($urandom_range(0, 1));
        if (resp_valid !== 1'b1 || resp_z !== ez || resp_hi !== ehi || resp_lo !== elo ||
            resp_dbz !== edbz || resp_illegal !== eill || alu_select !== 12'd0) heldBad++;
      end
      checkOutput("held under back-pressure", heldBad, 0);
    end

    resp_ready = 1'b1; req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
    checkOutput("resp_valid after handshake", resp_valid, 0);
    checkOutput("req_ready after handshake", req_ready, 1);
  endtask

  task automatic resetMidDivide();
    int stray;
    @(negedge clk);
    req_valid = 1'b1; req_op = 4'd9; req_a = 32'd1000; req_b = 32'd3;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (9) @(negedge clk);
    checkOutput("select before mid-divide reset", alu_select, 12'h200);
    clr = 1'b0;
    #1;
    checkResetState("mid-divide reset");
    repeat (2) @(negedge clk);
    clr = 1'b1;
    stray = 0;
    repeat (6) begin
      @(negedge clk);
      if (resp_valid !== 1'b0 || alu_select !== 12'd0) stray++;
    end
    checkOutput("no response after reset", stray, 0);
  endtask

  initial begin
    clr = 1'b0; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0; resp_ready = 1'b0;
    repeat (3) @(negedge clk);
    checkResetState("power-on reset");
    clr = 1'b1;

    applyStimulus(4'd0, 32'd124, 32'd7, 0);
    applyStimulus(4'd8, 32'd124, 32'd7, 0);
    applyStimulus(4'd1, 32'd124, 32'd7, 1);
    applyStimulus(4'd9, 32'd124, 32'd7, 5);
    applyStimulus(4'd9, 32'd124, 32'd0, 0);
    applyStimulus(4'd13, 32'd55, 32'd66, 2);
    resetMidDivide();
    applyStimulus(4'd0, 32'd124, 32'd7, 0);

    for (int n = 0; n < 40; n++) begin
      logic [3:0]  op;
      logic [31:0] a, b;
      op = 4'($urandom_range(0, 15));
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      applyStimulus(op, a, b, $urandom_range(0, 4));
    end

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
